// File: rtl/bbox_sweep_scheduler_if.sv
// Shared fixed-point geometry types and the scheduler's bundled ports: ray in,
// box RAM read, intersect unit request/response, and closest-hit result.
package bbox_sweep_pkg;
  typedef logic signed [27:0] scalar_t;
  localparam scalar_t INFINITY_28 = 28'sh7ffffff;

  typedef struct packed {
    scalar_t x;
    scalar_t y;
    scalar_t z;
  } vec3_t;

  typedef struct packed {
    scalar_t x;
    scalar_t y;
  } vec2_t;

  typedef struct packed {
    vec3_t lo;
    vec3_t hi;
  } bbox_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
endpackage

interface bbox_sweep_if #(parameter int MAX_BOXES = 16);
  import bbox_sweep_pkg::*;
  localparam int AW = $clog2(MAX_BOXES);
  localparam int CW = $clog2(MAX_BOXES + 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // sender holds its payload stable while valid is high and ready is low.
  logic          ray_valid;
  logic          ray_ready;
  vec3_t         ray_orig_in;
  vec3_t         inv_ray_dir_in;
  logic [CW-1:0] num_boxes_in;

  logic          box_rd_en;
  logic [AW-1:0] box_rd_addr;
  bbox_t         box_rd_data;

  vec3_t         isect_ray_orig;
  vec3_t         isect_inv_dir;
  bbox_t         isect_box;
  vec2_t         isect_prev_range;
  logic          isect_hit;
  vec2_t         isect_range;

  logic          res_valid;
  logic          res_ready;
  logic          res_hit;
  logic [AW-1:0] res_box_idx;
  scalar_t       res_t_near;
  logic          busy;

  modport master (
    input  ray_valid, ray_orig_in, inv_ray_dir_in, num_boxes_in,
    input  box_rd_data, isect_hit, isect_range, res_ready,
    output ray_ready, box_rd_en, box_rd_addr,
    output isect_ray_orig, isect_inv_dir, isect_box, isect_prev_range,
    output res_valid, res_hit, res_box_idx, res_t_near, busy
  );

  modport slave (
    output ray_valid, ray_orig_in, inv_ray_dir_in, num_boxes_in,
    output box_rd_data, isect_hit, isect_range, res_ready,
    input  ray_ready, box_rd_en, box_rd_addr,
    input  isect_ray_orig, isect_inv_dir, isect_box, isect_prev_range,
    input  res_valid, res_hit, res_box_idx, res_t_near, busy
  );
endinterface

// File: rtl/bbox_sweep_scheduler.sv
// Sweeps one ray across N boxes, issuing one intersect test per cycle, and
// keeps the closest hit using a tag pipe aligned to the intersect results.
module bbox_sweep_scheduler
  import bbox_sweep_pkg::*;
#(
  parameter int MAX_BOXES  = 16,
  parameter int ISECT_LAT  = 2,
  parameter int BOX_RD_LAT = 1
) (
  input  logic         sysclk,
  input  logic         rst,
  bbox_sweep_if.master bus,
  output state_e       dbg_state
);
  localparam int AW        = $clog2(MAX_BOXES);
  localparam int CW        = $clog2(MAX_BOXES + 1);
  localparam int TAG_DEPTH = BOX_RD_LAT + ISECT_LAT;

  state_e                state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         n_q, n_d;
  scalar_t               best_t_q, best_t_d;
  logic                  best_hit_q, best_hit_d;
  logic [AW-1:0]         best_idx_q, best_idx_d;
  logic [TAG_DEPTH-1:0]  tag_vld_q, tag_vld_d;
  logic [AW-1:0]         tag_idx_q [TAG_DEPTH];
  logic [AW-1:0]         tag_idx_d [TAG_DEPTH];
  vec3_t                 orig_q, orig_d;
  vec3_t                 inv_dir_q, inv_dir_d;
  bbox_t                 box_q, box_d;
  scalar_t               prev_y_q, prev_y_d;
  logic                  issue;
  scalar_t               t_near;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    n_d        = n_q;
    best_t_d   = best_t_q;
    best_hit_d = best_hit_q;
    best_idx_d = best_idx_q;
    orig_d     = orig_q;
    inv_dir_d  = inv_dir_q;
    box_d      = bus.box_rd_data;
    prev_y_d   = best_t_q;
    issue      = (state_q == ISSUE);
    tag_vld_d  = '0;
    tag_vld_d[0] = issue;
    tag_idx_d[0] = idx_q;
    for (int i = 1; i < TAG_DEPTH; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end

    // A negative entry distance means the origin sits inside the box.
    t_near = (bus.isect_range.x < 0) ? '0 : bus.isect_range.x;
    if (tag_vld_q[TAG_DEPTH-1] && bus.isect_hit && (t_near < best_t_q)) begin
      best_t_d   = t_near;
      best_idx_d = tag_idx_q[TAG_DEPTH-1];
      best_hit_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.ray_valid) begin
          orig_d     = bus.ray_orig_in;
          inv_dir_d  = bus.inv_ray_dir_in;
          n_d        = bus.num_boxes_in;
          idx_d      = '0;
          best_t_d   = INFINITY_28;
          best_hit_d = 1'b0;
          best_idx_d = '0;
          state_d    = (bus.num_boxes_in == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        idx_d = idx_q + 1'b1;
        if (CW'(idx_q) == n_q - 1'b1) state_d = DRAIN;
      end
      // Leave as the final tail entry retires so the last update lands in DONE.
      DRAIN: if (tag_vld_d == '0) state_d = DONE;
      DONE:  if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      n_q        <= '0;
      best_t_q   <= INFINITY_28;
      best_hit_q <= 1'b0;
      best_idx_q <= '0;
      tag_vld_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      best_t_q   <= best_t_d;
      best_hit_q <= best_hit_d;
      best_idx_q <= best_idx_d;
      tag_vld_q  <= tag_vld_d;
    end
  end

  // Pure datapath; every consumer is qualified by state or a tag valid bit.
  always_ff @(posedge sysclk) begin
    orig_q    <= orig_d;
    inv_dir_q <= inv_dir_d;
    box_q     <= box_d;
    prev_y_q  <= prev_y_d;
    for (int i = 0; i < TAG_DEPTH; i++) tag_idx_q[i] <= tag_idx_d[i];
  end

  assign bus.ray_ready        = (state_q == IDLE);
  assign bus.box_rd_en        = issue;
  assign bus.box_rd_addr      = idx_q;
  assign bus.isect_ray_orig   = orig_q;
  assign bus.isect_inv_dir    = inv_dir_q;
  assign bus.isect_box        = box_q;
  assign bus.isect_prev_range = vec2_t'{x: '0, y: prev_y_q};
  assign bus.res_valid        = (state_q == DONE);
  assign bus.res_hit          = best_hit_q;
  assign bus.res_box_idx      = best_idx_q;
  assign bus.res_t_near       = best_t_q;
  assign bus.busy             = (state_q != IDLE);
  assign dbg_state            = state_q;
endmodule

// File: tb/tb_bbox_sweep_scheduler.sv
// Directed bench for bbox_sweep_scheduler with a 1-cycle box RAM model and a
// simple slab-style intersect model (hit when hi.x >= lo.x and hi.x >= 0).
module tb_bbox_sweep_scheduler;
  import bbox_sweep_pkg::*;

  logic   sysclk = 1'b0;
  logic   rst;
  state_e dbg_state;
  int     total = 0;
  int     bad = 0;

  bbox_sweep_if #(.MAX_BOXES(16)) bus();

  bbox_sweep_scheduler #(.MAX_BOXES(16), .ISECT_LAT(2), .BOX_RD_LAT(1)) dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 sysclk = ~sysclk;

  // ---------------- environment models ----------------
  bbox_t      ram [16];
  logic [3:0] rd_log [256];
  int         rd_total = 0;

  always @(posedge sysclk) begin
    if (bus.box_rd_en) begin
      bus.box_rd_data             <= ram[bus.box_rd_addr];
      rd_log[rd_total % 256]      <= bus.box_rd_addr;
      rd_total                    <= rd_total + 1;
    end
  end

  always @(posedge sysclk) begin
    bus.isect_hit   <= (bus.isect_box.hi.x >= bus.isect_box.lo.x) && (bus.isect_box.hi.x >= 0);
    bus.isect_range <= '{x: bus.isect_box.lo.x, y: bus.isect_box.hi.x};
  end

  function automatic bbox_t mk_box(input scalar_t lo_x, input scalar_t hi_x);
    bbox_t b;
    b      = '0;
    b.lo.x = lo_x;
    b.hi.x = hi_x;
    return b;
  endfunction

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q [$];
  vec3_t      saved_orig;
  int         rd_base;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_ray(input int n);
    rd_base = rd_total;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(4'(i));
    saved_orig         = '{x: scalar_t'(n * 3 + 1), y: scalar_t'(-2), z: scalar_t'(7)};
    bus.ray_orig_in    = saved_orig;
    bus.inv_ray_dir_in = '{x: scalar_t'(16), y: scalar_t'(-16), z: scalar_t'(1)};
    bus.num_boxes_in   = 5'(n);
    chk("ray_ready_before", bus.ray_ready, 1);
    bus.ray_valid = 1'b1;
    @(posedge sysclk);
    @(negedge sysclk);
    bus.ray_valid      = 1'b0;
    bus.ray_orig_in    = '0;
    bus.inv_ray_dir_in = '0;
    bus.num_boxes_in   = '0;
  endtask

  task automatic wait_res(input int exp_lat, input logic exp_hit, input int exp_idx,
                          input scalar_t exp_t);
    int cycles;
    cycles = 1;
    while (!bus.res_valid && cycles < 200) begin
      @(negedge sysclk);
      cycles++;
    end
    chk("latency", cycles, exp_lat);
    chk("res_valid", bus.res_valid, 1);
    chk("res_hit", bus.res_hit, exp_hit);
    chk("res_box_idx", bus.res_box_idx, exp_idx);
    chk("res_t_near", bus.res_t_near, exp_t);
    chk("ray_ready_done", bus.ray_ready, 0);
    chk("busy_done", bus.busy, 1);
    chk("state_done", dbg_state, DONE);
    chk("rd_count", rd_total - rd_base, exp_q.size());
    for (int i = 0; exp_q.size() > 0 && i < 16; i++)
      chk("rd_addr", rd_log[(rd_base + i) % 256], exp_q.pop_front());
    chk("orig_latched", bus.isect_ray_orig, saved_orig);
    chk("inv_dir_latched", bus.isect_inv_dir.y, scalar_t'(-16));
    chk("prev_range_x", bus.isect_prev_range.x, 0);
  endtask

  task automatic consume();
    bus.res_ready = 1'b1;
    @(posedge sysclk);
    @(negedge sysclk);
    bus.res_ready = 1'b0;
    chk("res_valid_cleared", bus.res_valid, 0);
    chk("ray_ready_idle", bus.ray_ready, 1);
    chk("busy_idle", bus.busy, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int   held_rd;
    logic found;
    rst                = 1'b1;
    bus.ray_valid      = 1'b0;
    bus.ray_orig_in    = '0;
    bus.inv_ray_dir_in = '0;
    bus.num_boxes_in   = '0;
    bus.res_ready      = 1'b0;
    for (int i = 0; i < 16; i++) ram[i] = mk_box(1, 0);
    repeat (3) @(negedge sysclk);

    chk("rst_ray_ready", bus.ray_ready, 1);
    chk("rst_box_rd_en", bus.box_rd_en, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_hit", bus.res_hit, 0);
    chk("rst_res_box_idx", bus.res_box_idx, 0);
    chk("rst_res_t_near", bus.res_t_near, INFINITY_28);
    chk("rst_busy", bus.busy, 0);
    chk("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    @(negedge sysclk);

    // Only box 2 hit; the misses carry a smaller t that must be ignored.
    ram[2] = mk_box(5, 9);
    start_ray(4);
    wait_res(8, 1'b1, 2, scalar_t'(5));
    consume();

    // Equal distances: the lowest index wins.
    for (int i = 0; i < 3; i++) ram[i] = mk_box(7, 9);
    start_ray(3);
    wait_res(7, 1'b1, 0, scalar_t'(7));
    consume();

    // Empty sweep.
    start_ray(0);
    wait_res(1, 1'b0, 0, INFINITY_28);
    consume();

    // Origin inside box 1 clamps its distance to zero.
    ram[0] = mk_box(4, 9);
    ram[1] = mk_box(-3, 6);
    start_ray(2);
    wait_res(6, 1'b1, 1, scalar_t'(0));

    // Hold the result while another ray is offered; it must be ignored.
    held_rd          = rd_total;
    bus.ray_valid    = 1'b1;
    bus.num_boxes_in = 5'd5;
    for (int k = 0; k < 10; k++) begin
      @(negedge sysclk);
      chk("hold_valid", bus.res_valid, 1);
      chk("hold_idx", bus.res_box_idx, 1);
      chk("hold_t", bus.res_t_near, scalar_t'(0));
      chk("hold_ray_ready", bus.ray_ready, 0);
    end
    bus.ray_valid    = 1'b0;
    bus.num_boxes_in = '0;
    chk("hold_no_reads", rd_total, held_rd);
    consume();

    start_ray(1);
    wait_res(5, 1'b1, 0, scalar_t'(4));
    consume();

    // Abort a sweep of 8 at issue index 2; in-flight hits at t=1 must be dropped.
    for (int i = 0; i < 8; i++) ram[i] = mk_box(1, 5);
    start_ray(8);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (bus.box_rd_en && bus.box_rd_addr == 4'd2) found = 1'b1;
      else @(negedge sysclk);
    end
    chk("reach_idx2", found, 1);
    rst = 1'b1;
    @(posedge sysclk);
    @(negedge sysclk);
    rst = 1'b0;
    chk("abort_state", dbg_state, IDLE);
    chk("abort_rd_en", bus.box_rd_en, 0);
    chk("abort_ray_ready", bus.ray_ready, 1);
    chk("abort_res_valid", bus.res_valid, 0);
    chk("abort_reads", rd_total - rd_base, 3);
    exp_q.delete();

    ram[0] = mk_box(9, 12);
    ram[1] = mk_box(1, 0);
    start_ray(2);
    wait_res(6, 1'b1, 0, scalar_t'(9));
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
